// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
//   Accepts a byte stream (one message, big-endian byte order, in_last on
//   the final byte), builds the SHA-256 padded 512-bit blocks one byte per
//   cycle and hands each block to an external compression core with a
//   level-style start/ready handshake. After the final block the core's
//   chained state is captured as the digest and presented until accepted.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last   byte input stream
//   blk_start        level request to the core (high in ISSUE and WAIT)
//   blk_data         padded block, byte 0 at [511:504]
//   blk_first        1 = core starts from the IV, 0 = core chains its state
//   core_ready       core completion level
//   core_hash        core chained state {H0..H7}
//   digest_valid/digest_ready/digest   final hash output
//
// state  | meaning
// -------+------------------------------------------------------------
// FILL   | accepting message bytes into the block buffer
// PAD80  | writing the 0x80 terminator byte
// PADZ   | writing zero fill bytes
// PADLEN | writing the 64-bit big-endian bit length at bytes 56..63
// ISSUE  | block requested, waiting for the core to drop core_ready
// WAIT   | core busy, waiting for core_ready to rise
// REL    | one cycle with blk_start low; resume or go to OUT
// OUT    | digest presented until digest_ready

module sha256_msg_padder (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         blk_start,
  output logic [511:0] blk_data,
  output logic         blk_first,
  input  logic         core_ready,
  input  logic [255:0] core_hash,
  output logic         digest_valid,
  output logic [255:0] digest,
  input  logic         digest_ready
);

  typedef enum logic [2:0] {
    FILL   = 3'd0,
    PAD80  = 3'd1,
    PADZ   = 3'd2,
    PADLEN = 3'd3,
    ISSUE  = 3'd4,
    WAIT   = 3'd5,
    REL    = 3'd6,
    OUT    = 3'd7
  } state_t;

  state_t         state;
  state_t         nxt_state;
  state_t         resume;
  state_t         nxt_resume;
  logic           fin;
  logic           nxt_fin;
  logic [5:0]     ptr;
  logic [31:0]    len;
  logic           first_pending;
  logic [255:0]   digest_q;
  logic [7:0]     blk_mem [64];

  logic           wr_en;
  logic [7:0]     wr_byte;
  logic [63:0]    len_bits;
  logic [63:0]    len_sh;

  // ptr is 56..63 in PADLEN, so ptr[2:0] is the length byte index (MSB first)
  assign len_bits = {29'b0, len, 3'b000};
  assign len_sh   = len_bits << {ptr[2:0], 3'b000};

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= nxt_state;
  end

  // next-state logic
  always_comb begin
    nxt_state  = state;
    nxt_resume = resume;
    nxt_fin    = fin;
    case (state)
      FILL: begin
        if (in_valid) begin
          if (in_last) begin
            if (ptr == 6'd63) begin
              nxt_state  = ISSUE;
              nxt_resume = PAD80;
            end else begin
              nxt_state = PAD80;
            end
          end else if (ptr == 6'd63) begin
            nxt_state  = ISSUE;
            nxt_resume = FILL;
          end
        end
      end
      PAD80: begin
        if (ptr == 6'd63) begin
          nxt_state  = ISSUE;
          nxt_resume = PADZ;
        end else if (ptr == 6'd55) begin
          nxt_state = PADLEN;
        end else begin
          nxt_state = PADZ;
        end
      end
      PADZ: begin
        if (ptr == 6'd63) begin
          nxt_state  = ISSUE;
          nxt_resume = PADZ;
        end else if (ptr == 6'd55) begin
          nxt_state = PADLEN;
        end
      end
      PADLEN: begin
        if (ptr == 6'd63) begin
          nxt_state = ISSUE;
          nxt_fin   = 1'b1;
        end
      end
      ISSUE: if (!core_ready) nxt_state = WAIT;
      WAIT:  if (core_ready)  nxt_state = REL;
      REL:   nxt_state = fin ? OUT : resume;
      OUT: begin
        if (digest_ready) begin
          nxt_state = FILL;
          nxt_fin   = 1'b0;
        end
      end
      default: nxt_state = FILL;
    endcase
  end

  // output logic
  always_comb begin
    in_ready     = 1'b0;
    blk_start    = 1'b0;
    digest_valid = 1'b0;
    wr_en        = 1'b0;
    wr_byte      = 8'h00;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        wr_en    = in_valid;
        wr_byte  = in_data;
      end
      PAD80: begin
        wr_en   = 1'b1;
        wr_byte = 8'h80;
      end
      PADZ: wr_en = 1'b1;
      PADLEN: begin
        wr_en   = 1'b1;
        wr_byte = len_sh[63:56];
      end
      ISSUE, WAIT: blk_start = 1'b1;
      OUT: digest_valid = 1'b1;
      default: ;
    endcase
  end

  // block buffer, counters and digest
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      len           <= '0;
      fin           <= 1'b0;
      resume        <= FILL;
      first_pending <= 1'b1;
      digest_q      <= '0;
      for (int i = 0; i < 64; i++) blk_mem[i] <= '0;
    end else begin
      resume <= nxt_resume;
      fin    <= nxt_fin;
      if (wr_en) begin
        blk_mem[ptr] <= wr_byte;
        ptr          <= ptr + 6'd1;
      end
      if (state == FILL && in_valid) len <= len + 32'd1;
      if (state == REL) begin
        first_pending <= 1'b0;
        if (fin) digest_q <= core_hash;
      end
      if (state == OUT && digest_ready) begin
        len           <= '0;
        ptr           <= '0;
        first_pending <= 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < 64; g++) begin : g_pack
      assign blk_data[511-8*g -: 8] = blk_mem[g];
    end
  endgenerate

  assign blk_first = first_pending;
  assign digest    = digest_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_ready;
  logic         blk_start;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         core_ready;
  logic [255:0] core_hash;
  logic         digest_valid;
  logic [255:0] digest;
  logic         digest_ready;

  sha256_msg_padder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .blk_start(blk_start), .blk_data(blk_data), .blk_first(blk_first),
    .core_ready(core_ready), .core_hash(core_hash),
    .digest_valid(digest_valid), .digest(digest), .digest_ready(digest_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2047:0] K_ALL = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K_ALL[2047-32*t -: 32] + w[t];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // reference padding and digest, built from the message bytes alone
  logic [7:0]   msg [256];
  logic [511:0] exp_blk [4];
  logic [255:0] exp_dig;
  int           blk_idx;
  int           core_delay;
  int           cst;

  function automatic logic [7:0] pat(input int mode, input int i);
    case (mode)
      0:       return 8'h61;
      1:       return 8'(8'h61 + i);
      default: return 8'((i * 7 + 3) & 255);
    endcase
  endfunction

  task automatic build_model(input int n, input int mode);
    int nb;
    logic [63:0] bitlen;
    logic [7:0] v;
    int k;
    for (int i = 0; i < n; i++) msg[i] = pat(mode, i);
    nb = (n + 9 + 63) / 64;
    bitlen = 64'(n) * 64'd8;
    exp_dig = IV;
    for (int b = 0; b < 4; b++) exp_blk[b] = '1;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 64; j++) begin
        k = b * 64 + j;
        if (k < n)       v = msg[k];
        else if (k == n) v = 8'h80;
        else             v = 8'h00;
        if (b == nb - 1 && j >= 56) v = bitlen[63-8*(j-56) -: 8];
        exp_blk[b][511-8*j -: 8] = v;
      end
      exp_dig = sha_compress(exp_dig, exp_blk[b]);
    end
  endtask

  // behavioural compression core: drops core_ready when it takes a block,
  // raises it with the new chained state after core_delay cycles, and only
  // takes another block after blk_start has been seen low
  initial begin
    logic [511:0] cap;
    logic         capf;
    logic [255:0] hstate;
    int           cnt;
    int           unstable;
    cst = 0; core_ready = 1'b1; core_hash = '0; hstate = '0; cnt = 0; unstable = 0;
    cap = '0; capf = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cst = 0; core_ready = 1'b1; core_hash = '0;
      end else begin
        case (cst)
          0: if (blk_start) begin
            chk("blk_data", blk_data, (blk_idx < 4) ? exp_blk[blk_idx] : '1);
            chk("blk_first", 512'(blk_first), 512'(blk_idx == 0));
            cap = blk_data; capf = blk_first;
            hstate = sha_compress(blk_first ? IV : hstate, blk_data);
            blk_idx++;
            cnt = core_delay; unstable = 0; core_ready = 1'b0; cst = 1;
          end
          1: begin
            if (!blk_start || blk_data !== cap || blk_first !== capf) unstable++;
            if (cnt == 0) begin
              chk("blk_hold_unstable", 512'(unstable), 512'd0);
              core_ready = 1'b1; core_hash = hstate; cst = 2;
            end else begin
              cnt--;
            end
          end
          default: begin
            chk("blk_start_release", 512'(blk_start), 512'd0);
            cst = 0;
          end
        endcase
      end
    end
  end

  task automatic send(input int n, input bit with_last);
    int i = 0;
    int budget = 0;
    while (i < n) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = with_last && (i == n - 1);
      if (in_ready) i++;
      budget++;
      if (budget > 4000) begin
        chk("send_timeout", 512'(i), 512'(n));
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_msg(input int n, input int mode, input int exp_blocks,
                         input int delay, input int hold);
    int t = 0;
    int bad = 0;
    logic [255:0] d0;
    build_model(n, mode);
    blk_idx = 0;
    core_delay = delay;
    send(n, 1'b1);
    while (!digest_valid && t < 3000) begin
      if (in_ready) bad++;
      @(negedge clk);
      t++;
    end
    chk("digest_valid", 512'(digest_valid), 512'd1);
    chk("in_ready_low_until_digest", 512'(bad), 512'd0);
    chk("block_count", 512'(blk_idx), 512'(exp_blocks));
    chk("digest", 512'(digest), 512'(exp_dig));
    if (n == 3 && mode == 1) chk("digest_abc", 512'(digest), 512'(ABC_DIGEST));
    d0 = digest;
    bad = 0;
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1; in_data = 8'hff; in_last = 1'b0;
      @(negedge clk);
      if (!digest_valid || digest !== d0 || in_ready) bad++;
    end
    in_valid = 1'b0;
    if (hold > 0) chk("digest_hold", 512'(bad), 512'd0);
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    chk("digest_valid_drop", 512'(digest_valid), 512'd0);
    chk("in_ready_after_out", 512'(in_ready), 512'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 512'(in_ready), 512'd1);
    chk({tag, "_blk_start"}, 512'(blk_start), 512'd0);
    chk({tag, "_blk_first"}, 512'(blk_first), 512'd1);
    chk({tag, "_digest_valid"}, 512'(digest_valid), 512'd0);
    chk({tag, "_digest"}, 512'(digest), 512'd0);
    chk({tag, "_blk_data"}, blk_data, 512'd0);
  endtask

  typedef struct {
    int n;
    int mode;
    int exp_blocks;
    int delay;
    int hold;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int t;
    vecs[0] = '{n: 3,   mode: 1, exp_blocks: 1, delay: 2,  hold: 10};
    vecs[1] = '{n: 3,   mode: 1, exp_blocks: 1, delay: 2,  hold: 0};
    vecs[2] = '{n: 55,  mode: 0, exp_blocks: 1, delay: 3,  hold: 0};
    vecs[3] = '{n: 56,  mode: 0, exp_blocks: 2, delay: 2,  hold: 0};
    vecs[4] = '{n: 64,  mode: 2, exp_blocks: 2, delay: 5,  hold: 0};
    vecs[5] = '{n: 119, mode: 2, exp_blocks: 2, delay: 1,  hold: 0};
    vecs[6] = '{n: 120, mode: 2, exp_blocks: 3, delay: 70, hold: 0};
    vecs[7] = '{n: 1,   mode: 2, exp_blocks: 1, delay: 0,  hold: 3};
    vecs[8] = '{n: 63,  mode: 1, exp_blocks: 2, delay: 4,  hold: 0};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; digest_ready = 1'b0;
    blk_idx = 0; core_delay = 2;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int v = 0; v < 9; v++)
      run_msg(vecs[v].n, vecs[v].mode, vecs[v].exp_blocks, vecs[v].delay, vecs[v].hold);

    // reset while a block is in flight: 64 bytes without in_last
    for (int i = 0; i < 64; i++) msg[i] = pat(2, i);
    for (int i = 0; i < 64; i++) exp_blk[0][511-8*i -: 8] = msg[i];
    blk_idx = 0;
    core_delay = 200;
    send(64, 1'b0);
    t = 0;
    while (cst != 1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("wait_in_flight", 512'(blk_start && !core_ready), 512'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_wait");
    rst = 1'b0;
    run_msg(3, 1, 1, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
